// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 constants and the write-DMA state type.
//   AXI_RESP_*  : BRESP/RRESP encodings
//   AXI_BURST_* : AWBURST/ARBURST encodings
//   dma_state_e : write-DMA controller states
// -----------------------------------------------------------------------------
package axi4_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } dma_state_e;

endpackage

// File: rtl/axi4_burst_calc.sv
// -----------------------------------------------------------------------------
// axi4_burst_calc
// Combinational burst sizing: beats = min(remaining, MAXB, beats left in the
// current 4 KB page). The address is expected to be STBW-aligned, so at least
// one beat always fits in the page.
//   addr      : in,  12  page offset (addr[11:0]) of the next burst
//   remaining : in,  REMW beats still to be written for the command
//   beats     : out, 9   beats for the next burst (1..256)
// -----------------------------------------------------------------------------
module axi4_burst_calc #(
    parameter int REMW = 17,
    parameter int STBW = 32,
    parameter int MAXB = 16
) (
    input  logic [11:0]     addr,
    input  logic [REMW-1:0] remaining,
    output logic [8:0]      beats
);

    localparam int SZW = $clog2(STBW);

    logic [12:0] page_beats;

    always_comb begin
        page_beats = (13'd4096 - {1'b0, addr}) >> SZW;
        beats      = 9'(MAXB);
        // remaining[8:0] is only taken when it is already below MAXB (<=256)
        if (remaining < REMW'(MAXB)) begin
            beats = remaining[8:0];
        end
        // page_beats[8:0] is only taken when it is below the current limit
        if (page_beats < 13'(beats)) begin
            beats = page_beats[8:0];
        end
    end

endmodule

// File: rtl/axi4_m_dma_w.sv
// -----------------------------------------------------------------------------
// axi4_m_dma_w
// Stream-to-AXI4 write DMA. A command (id, start address, byte count) is split
// into INCR bursts of at most MAXB beats that never cross a 4 KB page. Only one
// burst is outstanding at a time. Write data is passed straight through from
// the input stream to the W channel; the last beat of the command carries a
// partial strobe when the byte count is not a multiple of STBW. Any non-OKAY
// BRESP or BID mismatch makes the completion report an error.
// Ports:
//   i_clk, i_rst                 : clock, async active-high reset
//   i_cmd_* / o_cmd_ready        : command handshake (id, addr, bytes)
//   i_dat_* / o_dat_ready        : write-data stream
//   o_m_aw* / i_m_awready        : AXI4 AW channel (registered outputs)
//   o_m_w*  / i_m_wready         : AXI4 W channel
//   i_m_b*  / o_m_bready         : AXI4 B channel
//   o_done_valid, o_done_err     : one-cycle completion pulse and status
// -----------------------------------------------------------------------------
module axi4_m_dma_w
    import axi4_pkg::*;
#(
    parameter int TAGW = 3,
    parameter int ADRW = 32,
    parameter int DATW = 256,
    parameter int STBW = DATW / 8,
    parameter int LENW = 16,
    parameter int MAXB = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    output logic            o_cmd_ready,
    input  logic [TAGW-1:0] i_cmd_id,
    input  logic [ADRW-1:0] i_cmd_addr,
    input  logic [LENW-1:0] i_cmd_bytes,
    input  logic            i_dat_valid,
    output logic            o_dat_ready,
    input  logic [DATW-1:0] i_dat_data,
    output logic [TAGW-1:0] o_m_awid,
    output logic [ADRW-1:0] o_m_awaddr,
    output logic [7:0]      o_m_awlen,
    output logic [2:0]      o_m_awsize,
    output logic [1:0]      o_m_awburst,
    output logic            o_m_awvalid,
    input  logic            i_m_awready,
    output logic [DATW-1:0] o_m_wdata,
    output logic [STBW-1:0] o_m_wstrb,
    output logic            o_m_wlast,
    output logic            o_m_wvalid,
    input  logic            i_m_wready,
    input  logic [TAGW-1:0] i_m_bid,
    input  logic [1:0]      i_m_bresp,
    input  logic            i_m_bvalid,
    output logic            o_m_bready,
    output logic            o_done_valid,
    output logic            o_done_err
);

    localparam int SZW  = $clog2(STBW);
    localparam int REMW = LENW + 1;     // ceil(bytes/STBW) can never exceed this

    dma_state_e      state_reg, state_next;
    logic [TAGW-1:0] id_reg, id_next;
    logic [ADRW-1:0] addr_reg, addr_next;
    logic [SZW-1:0]  tail_reg, tail_next;   // bytes mod STBW
    logic [REMW-1:0] rem_reg, rem_next;
    logic [8:0]      beat_reg, beat_next;
    logic            err_reg, err_next;

    logic [TAGW-1:0] awid_reg;
    logic [ADRW-1:0] awaddr_reg;
    logic [7:0]      awlen_reg;
    logic [2:0]      awsize_reg;
    logic [1:0]      awburst_reg;
    logic            awvalid_reg;

    logic [8:0]      calc_beats;
    logic [8:0]      burst_beats;
    logic            aw_load;
    logic            last_burst;
    logic [STBW-1:0] tail_mask;

    // Burst length of the AW currently in flight; awlen holds it until the B.
    assign burst_beats = {1'b0, awlen_reg} + 9'd1;
    assign last_burst  = (rem_reg == REMW'(burst_beats));

    // Sized from the values being loaded so the AW fields are registered on
    // the same edge that enters ADDR, with no extra bubble cycle.
    axi4_burst_calc #(
        .REMW (REMW),
        .STBW (STBW),
        .MAXB (MAXB)
    ) u_burst_calc (
        .addr      (addr_next[11:0]),
        .remaining (rem_next),
        .beats     (calc_beats)
    );

    assign aw_load = (state_next == ADDR) && (state_reg != ADDR);

    genvar gi;
    generate
        for (gi = 0; gi < STBW; gi++) begin : g_tail_mask
            assign tail_mask[gi] = (gi < int'(tail_reg));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        id_next      = id_reg;
        addr_next    = addr_reg;
        tail_next    = tail_reg;
        rem_next     = rem_reg;
        beat_next    = beat_reg;
        err_next     = err_reg;
        o_cmd_ready  = 1'b0;
        o_dat_ready  = 1'b0;
        o_m_wvalid   = 1'b0;
        o_m_wlast    = 1'b0;
        o_m_bready   = 1'b0;
        o_done_valid = 1'b0;
        o_done_err   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Gated by reset so ready is low for the whole reset window.
                o_cmd_ready = ~i_rst;
                if (i_cmd_valid) begin
                    id_next    = i_cmd_id;
                    addr_next  = i_cmd_addr & ~ADRW'(STBW - 1);
                    tail_next  = i_cmd_bytes[SZW-1:0];
                    rem_next   = (REMW'(i_cmd_bytes) + REMW'(STBW - 1)) >> SZW;
                    err_next   = 1'b0;
                    state_next = (i_cmd_bytes == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                if (i_m_awready) begin
                    beat_next  = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                o_m_wvalid  = i_dat_valid;
                o_dat_ready = i_m_wready;
                o_m_wlast   = (beat_reg == {1'b0, awlen_reg});
                if (i_dat_valid && i_m_wready) begin
                    beat_next = beat_reg + 9'd1;
                    if (o_m_wlast) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                o_m_bready = 1'b1;
                if (i_m_bvalid) begin
                    if ((i_m_bresp != AXI_RESP_OKAY) || (i_m_bid != id_reg)) begin
                        err_next = 1'b1;
                    end
                    rem_next   = rem_reg - REMW'(burst_beats);
                    addr_next  = addr_reg + (ADRW'(burst_beats) << SZW);
                    state_next = (rem_next != '0) ? ADDR : DONE;
                end
            end
            DONE: begin
                o_done_valid = 1'b1;
                o_done_err   = err_reg;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            addr_reg    <= '0;
            tail_reg    <= '0;
            rem_reg     <= '0;
            beat_reg    <= '0;
            err_reg     <= 1'b0;
            awid_reg    <= '0;
            awaddr_reg  <= '0;
            awlen_reg   <= '0;
            awsize_reg  <= '0;
            awburst_reg <= '0;
            awvalid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            addr_reg    <= addr_next;
            tail_reg    <= tail_next;
            rem_reg     <= rem_next;
            beat_reg    <= beat_next;
            err_reg     <= err_next;
            awvalid_reg <= (state_next == ADDR);
            if (aw_load) begin
                awid_reg    <= id_next;
                awaddr_reg  <= addr_next;
                awlen_reg   <= 8'(calc_beats - 9'd1);
                awsize_reg  <= 3'(SZW);
                awburst_reg <= AXI_BURST_INCR;
            end
        end
    end

    assign o_m_awid    = awid_reg;
    assign o_m_awaddr  = awaddr_reg;
    assign o_m_awlen   = awlen_reg;
    assign o_m_awsize  = awsize_reg;
    assign o_m_awburst = awburst_reg;
    assign o_m_awvalid = awvalid_reg;

    assign o_m_wdata = i_dat_data;
    assign o_m_wstrb = (o_m_wlast && last_burst && (tail_reg != '0)) ? tail_mask : '1;

endmodule

// File: tb/tb_axi4_m_dma_w.sv
// -----------------------------------------------------------------------------
// tb_axi4_m_dma_w
// Directed and randomized checks of axi4_m_dma_w against a burst-list model
// computed from byte counts, page boundaries and the burst limit.
// -----------------------------------------------------------------------------
module tb_axi4_m_dma_w;

    logic         clk;
    logic         i_rst;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [2:0]   i_cmd_id;
    logic [31:0]  i_cmd_addr;
    logic [15:0]  i_cmd_bytes;
    logic         i_dat_valid;
    logic         o_dat_ready;
    logic [255:0] i_dat_data;
    logic [2:0]   o_m_awid;
    logic [31:0]  o_m_awaddr;
    logic [7:0]   o_m_awlen;
    logic [2:0]   o_m_awsize;
    logic [1:0]   o_m_awburst;
    logic         o_m_awvalid;
    logic         i_m_awready;
    logic [255:0] o_m_wdata;
    logic [31:0]  o_m_wstrb;
    logic         o_m_wlast;
    logic         o_m_wvalid;
    logic         i_m_wready;
    logic [2:0]   i_m_bid;
    logic [1:0]   i_m_bresp;
    logic         i_m_bvalid;
    logic         o_m_bready;
    logic         o_done_valid;
    logic         o_done_err;

    int checks   = 0;
    int failures = 0;

    axi4_m_dma_w dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_id     (i_cmd_id),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_bytes  (i_cmd_bytes),
        .i_dat_valid  (i_dat_valid),
        .o_dat_ready  (o_dat_ready),
        .i_dat_data   (i_dat_data),
        .o_m_awid     (o_m_awid),
        .o_m_awaddr   (o_m_awaddr),
        .o_m_awlen    (o_m_awlen),
        .o_m_awsize   (o_m_awsize),
        .o_m_awburst  (o_m_awburst),
        .o_m_awvalid  (o_m_awvalid),
        .i_m_awready  (i_m_awready),
        .o_m_wdata    (o_m_wdata),
        .o_m_wstrb    (o_m_wstrb),
        .o_m_wlast    (o_m_wlast),
        .o_m_wvalid   (o_m_wvalid),
        .i_m_wready   (i_m_wready),
        .i_m_bid      (i_m_bid),
        .i_m_bresp    (i_m_bresp),
        .i_m_bvalid   (i_m_bvalid),
        .o_m_bready   (o_m_bready),
        .o_done_valid (o_done_valid),
        .o_done_err   (o_done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One whole command: model the burst list, then act as AXI slave and
    // stream source with random stalls, checking every handshake.
    task automatic run_cmd(input logic [2:0] id, input logic [31:0] addr,
                           input logic [15:0] bytes, input int err_burst,
                           input bit bid_bad, input string name);
        int ea[$];
        int el[$];
        int a, tot, left, pg, b, tail, gbeat, guard, k;
        logic [31:0]  estrb;
        logic [255:0] d;
        bit eerr, v, r;

        a    = int'(addr) & ~31;
        tot  = (int'(bytes) + 31) / 32;
        left = tot;
        while (left > 0) begin
            pg = (4096 - (a % 4096)) / 32;
            b  = left;
            if (b > 16) b = 16;
            if (b > pg) b = pg;
            ea.push_back(a);
            el.push_back(b);
            a    += b * 32;
            left -= b;
        end
        tail  = int'(bytes) % 32;
        eerr  = 1'b0;
        gbeat = 0;

        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_id    = id;
        i_cmd_addr  = addr;
        i_cmd_bytes = bytes;
        #1 chk({name, ":cmd_ready"}, o_cmd_ready, 1);
        @(negedge clk);
        i_cmd_valid = 1'b0;

        for (int bi = 0; bi < ea.size(); bi++) begin
            guard = 0;
            while (o_m_awvalid !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk({name, ":awvalid"}, o_m_awvalid, 1);
            chk({name, ":awaddr"},  o_m_awaddr, 32'(ea[bi]));
            chk({name, ":awlen"},   o_m_awlen, 8'(el[bi] - 1));
            chk({name, ":awsize"},  o_m_awsize, 3'd5);
            chk({name, ":awburst"}, o_m_awburst, 2'b01);
            chk({name, ":awid"},    o_m_awid, id);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk({name, ":aw_hold_valid"}, o_m_awvalid, 1);
                chk({name, ":aw_hold_addr"},  o_m_awaddr, 32'(ea[bi]));
                chk({name, ":aw_hold_len"},   o_m_awlen, 8'(el[bi] - 1));
            end
            i_m_awready = 1'b1;
            @(negedge clk);
            i_m_awready = 1'b0;
            chk({name, ":aw_drop"}, o_m_awvalid, 0);

            k     = 0;
            guard = 0;
            while (k < el[bi] && guard < 500) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
                d = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
                i_dat_valid = v;
                i_m_wready  = r;
                i_dat_data  = d;
                #1;
                chk({name, ":wvalid"},    o_m_wvalid, v);
                chk({name, ":dat_ready"}, o_dat_ready, r);
                if (v && r) begin
                    estrb = (gbeat == tot - 1 && tail != 0) ? ((32'h1 << tail) - 32'h1)
                                                            : 32'hFFFF_FFFF;
                    chk({name, ":wstrb"}, o_m_wstrb, estrb);
                    chk({name, ":wlast"}, o_m_wlast, (k == el[bi] - 1));
                    chk({name, ":wdata"}, o_m_wdata, d);
                    k++;
                    gbeat++;
                end
                @(negedge clk);
                guard++;
            end
            i_dat_valid = 1'b0;
            i_m_wready  = 1'b0;

            repeat ($urandom_range(0, 2)) begin
                chk({name, ":bready_wait"}, o_m_bready, 1);
                chk({name, ":no_aw_before_b"}, o_m_awvalid, 0);
                @(negedge clk);
            end
            i_m_bvalid = 1'b1;
            i_m_bresp  = (bi == err_burst) ? 2'b10 : 2'b00;
            i_m_bid    = (bid_bad && bi == 0) ? ~id : id;
            if (bi == err_burst || (bid_bad && bi == 0)) eerr = 1'b1;
            #1 chk({name, ":bready"}, o_m_bready, 1);
            @(negedge clk);
            i_m_bvalid = 1'b0;
            i_m_bresp  = 2'b00;
        end

        chk({name, ":done_valid"}, o_done_valid, 1);
        chk({name, ":done_err"},   o_done_err, eerr);
        chk({name, ":done_no_aw"}, o_m_awvalid, 0);
        @(negedge clk);
        chk({name, ":done_pulse_end"}, o_done_valid, 0);
        chk({name, ":idle_ready"},     o_cmd_ready, 1);
        $display("cmd %s id=%0d addr=%08h bytes=%0d bursts=%0d beats=%0d err=%0b",
                 name, id, addr, bytes, ea.size(), tot, eerr);
    endtask

    initial begin
        i_rst       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_id    = '0;
        i_cmd_addr  = '0;
        i_cmd_bytes = '0;
        i_dat_valid = 1'b1;
        i_m_wready  = 1'b1;
        i_dat_data  = '0;
        i_m_awready = 1'b0;
        i_m_bid     = '0;
        i_m_bresp   = 2'b00;
        i_m_bvalid  = 1'b0;

        // Reset state, with stream inputs active to show nothing leaks through.
        repeat (2) @(negedge clk);
        #1;
        chk("rst:cmd_ready",  o_cmd_ready, 0);
        chk("rst:awvalid",    o_m_awvalid, 0);
        chk("rst:wvalid",     o_m_wvalid, 0);
        chk("rst:dat_ready",  o_dat_ready, 0);
        chk("rst:bready",     o_m_bready, 0);
        chk("rst:done_valid", o_done_valid, 0);
        chk("rst:awaddr",     o_m_awaddr, 0);
        chk("rst:awlen",      o_m_awlen, 0);
        i_dat_valid = 1'b0;
        i_m_wready  = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;

        run_cmd(3'd1, 32'h0000_1000, 16'd64,   -1, 1'b0, "single_burst");
        run_cmd(3'd2, 32'h0000_0FC0, 16'd256,  -1, 1'b0, "page_split");
        run_cmd(3'd3, 32'h0000_2000, 16'd600,  -1, 1'b0, "partial_tail");
        run_cmd(3'd4, 32'h0000_0040, 16'd0,    -1, 1'b0, "zero_bytes");
        run_cmd(3'd5, 32'h0000_5000, 16'd1600,  1, 1'b0, "slverr_burst2");
        run_cmd(3'd6, 32'h0000_6000, 16'd100,  -1, 1'b1, "bid_mismatch");
        run_cmd(3'd0, 32'h0000_7013, 16'd70,   -1, 1'b0, "unaligned_addr");

        // Reset in the middle of a data burst.
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_id    = 3'd7;
        i_cmd_addr  = 32'h0000_3000;
        i_cmd_bytes = 16'd600;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        chk("mid_rst:awvalid_pre", o_m_awvalid, 1);
        i_m_awready = 1'b1;
        @(negedge clk);
        i_m_awready = 1'b0;
        i_dat_valid = 1'b1;
        i_m_wready  = 1'b1;
        #1 chk("mid_rst:wvalid_pre", o_m_wvalid, 1);
        repeat (2) @(negedge clk);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst:wvalid",     o_m_wvalid, 0);
        chk("mid_rst:dat_ready",  o_dat_ready, 0);
        chk("mid_rst:awvalid",    o_m_awvalid, 0);
        chk("mid_rst:bready",     o_m_bready, 0);
        chk("mid_rst:cmd_ready",  o_cmd_ready, 0);
        chk("mid_rst:done_valid", o_done_valid, 0);
        chk("mid_rst:awaddr",     o_m_awaddr, 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst:no_done", o_done_valid, 0);
        end
        i_dat_valid = 1'b0;
        i_m_wready  = 1'b0;
        i_rst       = 1'b0;
        #1;
        chk("post_rst:no_done",   o_done_valid, 0);
        chk("post_rst:cmd_ready", o_cmd_ready, 1);
        $display("cmd mid_reset id=7 addr=00003000 bytes=600 abandoned");
        run_cmd(3'd7, 32'h0000_3000, 16'd600, -1, 1'b0, "after_reset");

        // Randomized commands near page boundaries with random error injection.
        for (int n = 0; n < 12; n++) begin
            logic [31:0] ra;
            logic [15:0] rb;
            int          eb;
            ra = $urandom & 32'h0000_3FFF;
            rb = 16'($urandom_range(0, 1500));
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_cmd(3'($urandom), ra, rb, eb, ($urandom_range(0, 7) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
